// File: rtl/ram_sync_read_master.sv
// ram_sync_read_master: bridges a valid/ready request stream (single writes and
// incrementing read bursts) onto a single-port synchronous-read RAM, returning
// read data through a 4-entry response buffer. Read beats are issued only when
// the buffer is guaranteed to have room for them once their data arrives.
module ram_sync_read_master #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32,
  parameter int LWIDTH = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  input  logic [LWIDTH-1:0] req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    RBURST = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] burst_addr_q, burst_addr_d;
  logic [LWIDTH-1:0] remaining_q, remaining_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;

  logic [DWIDTH-1:0] fifo_data_q [4];
  logic [3:0]        fifo_last_q;
  logic [1:0]        wr_ptr_q, rd_ptr_q;
  logic [2:0]        count_q;

  logic              credit_ok;
  logic              issue, issue_last;
  logic              push, pop;

  // A beat may be issued only if every beat already buffered or in flight,
  // plus this one, fits in the 4-entry buffer.
  assign credit_ok = ({1'b0, count_q} + {3'b000, inflight_q}) < 4'd4;

  // Burst sequencing: next state, RAM drive and beat issue decisions.
  // Outputs are forced to zero while reset is held.
  always_comb begin
    state_d      = state_q;
    burst_addr_d = burst_addr_q;
    remaining_d  = remaining_q;
    issue        = 1'b0;
    issue_last   = 1'b0;
    req_ready    = 1'b0;
    ram_addr     = '0;
    ram_din      = '0;
    ram_we       = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          req_ready = credit_ok;
          ram_addr  = req_addr;
          ram_din   = req_wdata;
          if (req_valid && credit_ok) begin
            if (req_we) begin
              ram_we = 1'b1;
            end else begin
              issue = 1'b1;
              if (req_len == '0) begin
                issue_last = 1'b1;
              end else begin
                burst_addr_d = req_addr + AWIDTH'(1);
                remaining_d  = req_len;
                state_d      = RBURST;
              end
            end
          end
        end
        RBURST: begin
          ram_addr = burst_addr_q;
          if (credit_ok) begin
            issue        = 1'b1;
            burst_addr_d = burst_addr_q + AWIDTH'(1);
            remaining_d  = remaining_q - LWIDTH'(1);
            if (remaining_q == LWIDTH'(1)) begin
              issue_last = 1'b1;
              state_d    = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign inflight_d      = issue;
  assign inflight_last_d = issue_last;

  // Burst control registers and the one-cycle in-flight tag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      burst_addr_q    <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      burst_addr_q    <= burst_addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  assign push = inflight_q;
  assign pop  = rsp_valid & rsp_ready;

  // Response buffer: captures RAM data one cycle after issue; simultaneous
  // push and pop leave the occupancy unchanged.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        fifo_data_q[i] <= '0;
      end
      fifo_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= ram_dout;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rsp_valid = (count_q != 3'd0);
  assign rsp_data  = fifo_data_q[rd_ptr_q];
  assign rsp_last  = fifo_last_q[rd_ptr_q];
  assign busy      = (state_q != IDLE) | inflight_q | (count_q != 3'd0);

endmodule

// File: tb/tb_ram_sync_read_master.sv
// Bench for ram_sync_read_master: a table of single-cycle IDLE vectors, directed
// multi-cycle sequences, and randomized traffic checked against a scoreboard
// that expands each accepted read into its expected beats from a memory model.
module tb_ram_sync_read_master;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_len;
  logic        rsp_valid, rsp_ready, rsp_last, busy;
  logic [31:0] rsp_data;
  logic [2:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic        ram_we;

  ram_sync_read_master #(.AWIDTH(3), .DWIDTH(32), .LWIDTH(3)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .busy(busy),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clock = ~clock;

  // Synchronous-read RAM, read-before-write.
  logic [31:0] mem [8];
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  typedef struct {
    logic        v;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        exp_ready;
    logic        exp_we;
    logic [2:0]  exp_addr;
    logic [31:0] exp_din;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] mdl [8];
  exp_t        sb [$];
  logic [31:0] got [$];
  logic        last_valid, popped, acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge with inputs already driven; samples the
  // handshakes, updates the reference, returns at the next falling edge.
  task automatic step();
    exp_t e;
    #1;
    last_valid = rsp_valid;
    popped     = 1'b0;
    acc        = 1'b0;
    if (!reset) check("busy_vs_outstanding", {63'd0, busy}, {63'd0, sb.size() != 0});
    if (rsp_valid && rsp_ready) begin
      popped = 1'b1;
      got.push_back(rsp_data);
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_data", {32'd0, rsp_data}, {32'd0, e.d});
        check("rsp_last", {63'd0, rsp_last}, {63'd0, e.l});
      end
    end
    if (req_valid && req_ready) begin
      acc = 1'b1;
      if (req_we) begin
        mdl[req_addr] = req_wdata;
      end else begin
        for (int i = 0; i <= int'(req_len); i++) begin
          e.d = mdl[(int'(req_addr) + i) % 8];
          e.l = (i == int'(req_len));
          sb.push_back(e);
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic idle_in();
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_len = '0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d; req_len = '0;
    step();
    check("write_accepted", {63'd0, acc}, 64'd1);
    idle_in();
  endtask

  task automatic do_read(input logic [2:0] a, input logic [2:0] len);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = '0; req_len = len;
    step();
    check("read_accepted", {63'd0, acc}, 64'd1);
    idle_in();
  endtask

  task automatic drain();
    int n = 0;
    rsp_ready = 1'b1;
    idle_in();
    while ((sb.size() != 0 || busy) && n < 100) begin
      step();
      n++;
    end
    check("drain_empty", {32'd0, sb.size()}, 64'd0);
    check("drain_idle", {63'd0, busy}, 64'd0);
  endtask

  vec_t vecs [6];

  initial begin
    int n, first_i, last_i, pops;

    for (int i = 0; i < 8; i++) mdl[i] = '0;
    vecs[0] = '{1'b1, 1'b1, 3'd0, 32'h0000_0011, 1'b1, 1'b1, 3'd0, 32'h0000_0011};
    vecs[1] = '{1'b0, 1'b0, 3'd5, 32'h0000_0055, 1'b1, 1'b0, 3'd5, 32'h0000_0055};
    vecs[2] = '{1'b1, 1'b1, 3'd7, 32'h0000_A5A5, 1'b1, 1'b1, 3'd7, 32'h0000_A5A5};
    vecs[3] = '{1'b1, 1'b1, 3'd1, 32'h1234_5678, 1'b1, 1'b1, 3'd1, 32'h1234_5678};
    vecs[4] = '{1'b0, 1'b1, 3'd2, 32'h0000_0000, 1'b1, 1'b0, 3'd2, 32'h0000_0000};
    vecs[5] = '{1'b1, 1'b1, 3'd3, 32'hDEAD_BEEF, 1'b1, 1'b1, 3'd3, 32'hDEAD_BEEF};

    // Reset held for three cycles with a live write request on the inputs.
    reset = 1'b1;
    rsp_ready = 1'b1;
    idle_in();
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 3'd5; req_wdata = 32'h1234; req_len = 3'd2;
    repeat (2) step();
    #1;
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_last",  {63'd0, rsp_last},  64'd0);
    check("rst_rsp_data",  {32'd0, rsp_data},  64'd0);
    check("rst_busy",      {63'd0, busy},      64'd0);
    check("rst_ram_we",    {63'd0, ram_we},    64'd0);
    check("rst_ram_addr",  {61'd0, ram_addr},  64'd0);
    check("rst_ram_din",   {32'd0, ram_din},   64'd0);
    @(negedge clock);
    reset = 1'b0;
    idle_in();
    #1;
    check("post_rst_ready", {63'd0, req_ready}, 64'd1);
    check("post_rst_busy",  {63'd0, busy},      64'd0);

    // Single-cycle IDLE pass-through vectors (last row is the 0xDEADBEEF write).
    for (int i = 0; i < 6; i++) begin
      req_valid = vecs[i].v; req_we = vecs[i].we;
      req_addr = vecs[i].addr; req_wdata = vecs[i].wdata; req_len = '0;
      #1;
      check("vec_req_ready", {63'd0, req_ready}, {63'd0, vecs[i].exp_ready});
      check("vec_ram_we",    {63'd0, ram_we},    {63'd0, vecs[i].exp_we});
      check("vec_ram_addr",  {61'd0, ram_addr},  {61'd0, vecs[i].exp_addr});
      check("vec_ram_din",   {32'd0, ram_din},   {32'd0, vecs[i].exp_din});
      step();
    end
    idle_in();

    // Read-back of 0xDEADBEEF with two-cycle latency.
    got.delete();
    do_read(3'd3, 3'd0);
    n = 0;
    do begin
      step();
      n++;
    end while (!last_valid && n < 10);
    check("t2_latency", n, 64'd2);
    drain();
    check("t2_count", {32'd0, got.size()}, 64'd1);
    if (got.size() >= 1) check("t2_data", {32'd0, got[0]}, 64'hDEAD_BEEF);

    // Preload through the master, then wrapping burst at full throughput.
    for (int i = 0; i < 8; i++) do_write(3'(i), 32'h100 + 32'(i));
    got.delete();
    do_read(3'd6, 3'd3);
    first_i = -1; last_i = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (popped) begin
        if (first_i < 0) first_i = i;
        last_i = i;
      end
    end
    check("t3_count", {32'd0, got.size()}, 64'd4);
    check("t3_back_to_back", 64'(last_i - first_i), 64'd3);
    if (got.size() == 4) begin
      check("t3_d0", {32'd0, got[0]}, 64'h106);
      check("t3_d1", {32'd0, got[1]}, 64'h107);
      check("t3_d2", {32'd0, got[2]}, 64'h100);
      check("t3_d3", {32'd0, got[3]}, 64'h101);
    end
    drain();

    // Backpressure: buffer fills to four beats and the burst stalls.
    got.delete();
    rsp_ready = 1'b0;
    do_read(3'd0, 3'd7);
    repeat (8) step();
    #1;
    check("t4_ram_addr_hold", {61'd0, ram_addr}, 64'd4);
    check("t4_busy",          {63'd0, busy},     64'd1);
    check("t4_rsp_valid",     {63'd0, rsp_valid}, 64'd1);
    check("t4_req_ready",     {63'd0, req_ready}, 64'd0);
    rsp_ready = 1'b1;
    pops = 0;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      step();
      if (popped) pops++;
      n++;
    end
    check("t4_beats", pops, 64'd8);
    check("t4_order_last", {32'd0, got.size() == 8 ? got[7] : 32'd0}, 64'h107);
    drain();

    // Reset in the middle of an 8-beat burst.
    do_read(3'd0, 3'd7);
    repeat (2) step();
    reset = 1'b1;
    sb.delete();
    #1;
    check("t5_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("t5_busy",      {63'd0, busy},      64'd0);
    step();
    reset = 1'b0;
    #1;
    check("t5_ready_idle", {63'd0, req_ready}, 64'd1);
    got.delete();
    do_read(3'd5, 3'd0);
    drain();
    check("t5_count", {32'd0, got.size()}, 64'd1);
    if (got.size() >= 1) check("t5_data", {32'd0, got[0]}, 64'h105);

    // Write right behind a read of the same address.
    got.delete();
    do_read(3'd2, 3'd0);
    do_write(3'd2, 32'hCAFE);
    do_read(3'd2, 3'd0);
    drain();
    check("t6_count", {32'd0, got.size()}, 64'd2);
    if (got.size() == 2) begin
      check("t6_old", {32'd0, got[0]}, 64'h102);
      check("t6_new", {32'd0, got[1]}, 64'hCAFE);
    end

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 1500; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = ($urandom % 3) == 0;
      req_addr  = 3'($urandom);
      req_wdata = $urandom;
      req_len   = 3'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
